// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder/subtractor family: widths,
// operator codes and the (G,P) prefix combine used by every sweep level.
package bk_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int LOG2W_DEFAULT = 4;

    typedef enum logic [0:0] {
        BK_OP_ADD = 1'b0,
        BK_OP_SUB = 1'b1
    } bk_op_e;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    // Combine a higher-order group with the adjacent lower-order group.
    function automatic bk_gp_t bk_gp_combine(input bk_gp_t hi, input bk_gp_t lo);
        bk_gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Index of the lowest set bit; picks the aligned group that closes carry[i].
    function automatic int bk_ctz(input int v);
        int n;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) n = i;
        end
        return n;
    endfunction

endpackage

// File: rtl/bk_prefix_up.sv
// Brent-Kung up-sweep: builds every aligned group (G,P) level from bit-level
// generate/propagate. Level 0 is the bit level, level LOG2W spans all bits.
module bk_prefix_up
    import bk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LOG2W = LOG2W_DEFAULT
) (
    input  logic [WIDTH-1:0]            g1,
    input  logic [WIDTH-1:0]            p1,
    output logic [LOG2W:0][WIDTH-1:0]   gg,
    output logic [LOG2W:0][WIDTH-1:0]   pp
);

    bk_gp_t hi;
    bk_gp_t lo;
    bk_gp_t cmb;

    // Group j of level k covers bits [j*2^k +: 2^k]; unused upper slots stay 0.
    always_comb begin
        gg    = '0;
        pp    = '0;
        hi    = '0;
        lo    = '0;
        cmb   = '0;
        gg[0] = g1;
        pp[0] = p1;
        for (int k = 1; k <= LOG2W; k++) begin
            for (int j = 0; j < WIDTH / 2; j++) begin
                if (j < (WIDTH >> k)) begin
                    hi.g = gg[k-1][2*j+1];
                    hi.p = pp[k-1][2*j+1];
                    lo.g = gg[k-1][2*j];
                    lo.p = pp[k-1][2*j];
                    cmb  = bk_gp_combine(hi, lo);
                    gg[k][j] = cmb.g;
                    pp[k][j] = cmb.p;
                end
            end
        end
    end

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined Brent-Kung subtractor (diff = a - b - bin) with
// valid/ready on both sides; stage 1 holds the up-sweep, stage 2 the carries.
module bk_sub_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam bk_op_e OP = BK_OP_SUB;

    logic [WIDTH-1:0]          bn;
    logic                      cin;
    logic [WIDTH-1:0]          g1;
    logic [WIDTH-1:0]          p1;
    logic [LOG2W:0][WIDTH-1:0] gg;
    logic [LOG2W:0][WIDTH-1:0] pp;

    logic                      s1_valid;
    logic [LOG2W:0][WIDTH-1:0] s1_g;
    logic [LOG2W:0][WIDTH-1:0] s1_p;
    logic                      s1_cin;
    logic                      s1_a_msb;
    logic                      s1_bn_msb;

    logic                      s1_adv;
    logic                      s2_adv;
    logic                      accept;

    logic [WIDTH:0]            carry;
    logic [WIDTH-1:0]          diff_c;
    logic                      ovf_c;
    logic                      unused_s1;

    // Subtraction runs on the adder datapath as a + ~b + ~bin.
    assign bn  = (OP == BK_OP_SUB) ? ~b : b;
    assign cin = (OP == BK_OP_SUB) ? ~bin : bin;
    assign g1  = a & bn;
    assign p1  = a ^ bn;

    bk_prefix_up #(
        .WIDTH (WIDTH),
        .LOG2W (LOG2W)
    ) u_up (
        .g1 (g1),
        .p1 (p1),
        .gg (gg),
        .pp (pp)
    );

    // Handshake: a beat moves on valid & ready in the same cycle. A stage
    // advances when it is empty or the stage after it advances, so in_ready
    // is combinational from out_ready and a full pipe streams without bubbles.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_g      <= '0;
            s1_p      <= '0;
            s1_cin    <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_bn_msb <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= accept;
            if (accept) begin
                s1_g      <= gg;
                s1_p      <= pp;
                s1_cin    <= cin;
                s1_a_msb  <= a[WIDTH-1];
                s1_bn_msb <= bn[WIDTH-1];
            end
        end
    end

    // Down-sweep: carry[i] closes the aligned group ending at bit i-1 onto the
    // carry at i minus that group's length (power-of-two i fall back to cin).
    always_comb begin
        carry    = '0;
        carry[0] = s1_cin;
        for (int i = 1; i <= WIDTH; i++) begin
            carry[i] = s1_g[bk_ctz(i)][(i >> bk_ctz(i)) - 1]
                     | (s1_p[bk_ctz(i)][(i >> bk_ctz(i)) - 1] & carry[i - (1 << bk_ctz(i))]);
        end
    end

    assign diff_c    = s1_p[0] ^ carry[WIDTH-1:0];
    assign ovf_c     = (s1_a_msb == s1_bn_msb) && (diff_c[WIDTH-1] != s1_a_msb);
    assign unused_s1 = ^{s1_g, s1_p};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_c;
                bout <= ~carry[WIDTH];
                ovf  <= ovf_c;
                zero <= (diff_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Self-checking bench for bk_sub_pipe: directed corner cases, backpressure,
// asynchronous reset mid-stream and random streaming against a reference model.
module tb_bk_sub_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    // Expected results, packed as {ovf, zero, bout, diff}.
    logic [W+2:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         stall_prev = 1'b0;
    logic [W+2:0] held_prev  = '0;

    bk_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] full;
        int         sres;
        logic       o;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        sres = int'($signed(x)) - int'($signed(y)) - int'(c);
        o    = (sres > 32767) || (sres < -32768);
        return {o, (full[W-1:0] == '0), full[W], full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on drain, check hold on stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {13'd0, ovf, zero, bout, diff}, {13'd0, held_prev});
            end
            if (out_valid && out_ready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_out: observed diff %h with empty queue expected none", diff);
                end
                if (exp_q.size() != 0)
                    check("result", {13'd0, ovf, zero, bout, diff}, {13'd0, exp_q.pop_front()});
            end
            stall_prev = out_valid && !out_ready;
            held_prev  = {ovf, zero, bout, diff};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        end
    end

    // Send one beat into an idle pipe and check 2-stage latency plus spec values.
    task automatic send_check(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                              input logic [W-1:0] ed, input logic eb, input logic eo,
                              input logic ez, input string tag);
        out_ready = 1'b1;
        a         = x;
        b         = y;
        bin       = c;
        in_valid  = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] bp_a[3];
        logic [W-1:0] bp_b[3];
        int           idx;
        int           n_acc;
        logic         acc;
        logic         got;

        bp_a = '{16'h0010, 16'h0020, 16'h0030};
        bp_b = '{16'h0001, 16'h0002, 16'h0003};

        // Reset state.
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {13'd0, ovf, zero, bout, diff}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic corners.
        send_check(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "basic");
        send_check(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "wrap");
        send_check(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "bin_ripple");
        send_check(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, "ovf");
        send_check(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, "zero");

        // Backpressure: only two beats fit while the consumer stalls.
        out_ready = 1'b0;
        idx       = 0;
        n_acc     = 0;
        a         = bp_a[0];
        b         = bp_b[0];
        bin       = 1'b0;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                idx++;
                if (idx < 3) begin
                    a = bp_a[idx];
                    b = bp_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("bp_accepted", n_acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_diff_held", {16'd0, diff}, 32'h0000_000F);
        @(posedge clk);
        #1 out_ready = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                got      = 1'b1;
                in_valid = 1'b0;
            end
        end
        check("bp_third_accepted", {31'd0, got}, 32'd1);
        for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("bp_drained", exp_q.size(), 32'd0);

        // Asynchronous reset with a full pipe.
        out_ready = 1'b0;
        a         = 16'h7FFF;
        b         = 16'hFFFF;
        bin       = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0000;
        b = 16'h0001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_data", {13'd0, ovf, zero, bout, diff}, {13'd0, 3'b101, 16'h8000});
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_outputs", {13'd0, ovf, zero, bout, diff}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_check(16'h0100, 16'h00FF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, "post_rst");

        // Random streaming with random valid/ready.
        for (int cyc = 0; cyc < 14000; cyc++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            b        = W'($urandom);
            case ($urandom_range(0, 7))
                0:       a = b;
                1:       a = 16'h8000;
                2:       a = 16'h7FFF;
                default: a = W'($urandom);
            endcase
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("random_drained", exp_q.size(), 32'd0);
        @(negedge clk);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
